fwd_hazard_ctrl: RTL
====================

Name: fwd_hazard_ctrl

Overview:
- Control end of the EX-stage operand forwarding muxes in the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Tracks destination-register tags of in-flight instructions in EX, MEM and WB.
- Produces the registered 2-bit select codes that drive both 3:1 operand muxes.
- Generates the load-use stall and counts stall cycles.

Parameters:
- REG_ADDR_W, 5, register-specifier width
- CNT_W, 16, width of stall_count

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- hold  in  1  global pipeline freeze (memory wait); all internal state frozen
- flush_id  in  1  kill instruction currently in ID (taken branch/jump)
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  REG_ADDR_W  ID source register A
- id_rt  in  REG_ADDR_W  ID source register B
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_rd  in  REG_ADDR_W  ID destination register, already rt/rd-resolved
- id_regwrite  in  1  ID instruction writes the register file
- id_memread  in  1  ID instruction is a load
- stall  out  1  combinational; hold PC and IF/ID, inject bubble into ID/EX
- fwd_a_sel  out  2  registered select for operand-A mux, valid during the instruction's EX cycle
- fwd_b_sel  out  2  same for operand B
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Select encoding:
  - 00 = register-file value
  - 01 = MEM/WB writeback data
  - 10 = EX/MEM ALU result
  - 11 = never driven
- Register file is write-first-half / read-second-half, so a WB-stage producer is never a hazard.
- Tag registers:
  - ex_{v,rd,rw,mr}
  - mem_{v,rd,rw}
  - wb_{v,rd,rw}
- A tag "matches" src when v & rw & (rd != 0) & (rd == src).
- hazA = id_valid & id_use_rs & ex_v & ex_mr & match(ex, id_rs); hazB is the same for rt.
- stall = (hazA | hazB) & ~flush_id. It is purely combinational and may be asserted while hold=1.
- Next-select for A (hazB analog for B):
  - if match(ex, id_rs) & id_use_rs → 10
  - else if match(mem, id_rs) & id_use_rs → 01
  - else 00
  - EX match has priority, giving the newest value.
- Per-edge priority:
  1. rst: all tag valids 0, rd/rw/mr 0, fwd_*_sel 00, stall_count 0. Resulting stall = 0.
  2. hold=1: every register keeps its value, including selects and stall_count.
  3. Else advance:
     - wb <= mem, mem <= ex.
     - ex <= ID tag if id_valid & ~flush_id & ~stall; otherwise a bubble (v=0, selects 00).
     - fwd_*_sel <= next-select if ID is issued, else 00.
     - stall_count increments when stall=1; it saturates at all-ones and does not wrap.
- Latency:
  - Selects appear exactly one cycle after the consumer is in ID and are stable for its EX cycle.
  - A load-use hazard costs exactly 1 stall cycle. After the stall, the load is in MEM and the consumer issues with select 01.
- Simultaneous cases:
  - flush_id with hazard → stall=0, bubble issued.
  - Reset mid-stall → stall drops the cycle after rst is sampled.
- A register specifier of 0 never forwards or stalls.

Optional Feature:
- Macro: FWD_HAZARD_FWD_EN.
- Defined: full forwarding as above.
- Undefined: no forwarding.
  - fwd_*_sel are held at 00.
  - hazA = id_valid & id_use_rs & (match(ex, id_rs) | match(mem, id_rs)); hazB analog. ex_mr is not needed.
  - A dependent instruction stalls up to 2 cycles until its producer reaches WB. stall_count counts those cycles.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with id_valid=1, id_rs=3, and a matching ex tag preloaded.
  - Required: stall=0, sels=00, stall_count=0 after release.
- EX forward:
  - Stimulus: issue add r5 (rw=1), then sub using rs=5, rt=6.
  - Required: cycle after the sub is in ID, fwd_a_sel=10 and fwd_b_sel=00; no stall.
- MEM forward:
  - Stimulus: add r7, then unrelated instruction, then consumer rt=7.
  - Required: fwd_b_sel=01.
  - Stimulus: repeat with both EX and MEM tags at r7.
  - Required: fwd_b_sel=10.
- Load-use:
  - Stimulus: lw r8, then consumer rs=8.
  - Required: stall=1 for exactly 1 cycle, then fwd_a_sel=01, stall_count=1.
  - Stimulus: repeat with flush_id=1 during the stall cycle.
  - Required: stall=0, bubble issued, sels=00.
- Hold/r0:
  - Stimulus: hold=1 for 3 cycles during a stall.
  - Required: sels and stall_count unchanged, stall remains 1.
  - Stimulus: producer rd=0 with consumer rs=0.
  - Required: sel=00, no stall.
- Macro undefined:
  - Stimulus: add r5, then consumer rs=5.
  - Required: stall=1 for 2 cycles, sels always 00, stall_count=2.
  - Stimulus: saturation preload at all-ones plus one more stall.
  - Required: count stays at all-ones.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
//   Control end of the EX-stage operand forwarding muxes in a 5-stage MIPS
//   pipeline. It keeps the destination tags of the instructions in EX, MEM
//   and WB, registers the 2-bit operand-mux selects for the instruction
//   entering EX, raises the combinational load-use stall, and counts stall
//   cycles with a saturating counter.
//
//   Optional feature macro: FWD_HAZARD_FWD_EN
//     defined   : full forwarding (EX/MEM -> 10, MEM/WB -> 01), load-use stall only
//     undefined : no forwarding, selects held at 00, a dependent instruction
//                 stalls until its producer has reached WB
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     hold                global freeze, every register keeps its value
//     flush_id            kill the instruction in ID
//     id_valid            ID holds a real instruction
//     id_rs, id_rt        ID source registers
//     id_use_rs/rt        ID instruction reads rs / rt
//     id_rd               ID destination register
//     id_regwrite         ID instruction writes the register file
//     id_memread          ID instruction is a load
//     stall               hold PC and IF/ID, bubble into ID/EX (combinational)
//     fwd_a_sel/b_sel     registered operand-mux selects for the EX cycle
//     stall_count         saturating count of stall cycles
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  flush_id,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    output logic                  stall,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      stall_count
);

    logic                  ex_v, ex_rw, ex_mr;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_v, mem_rw;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  wb_v, wb_rw;
    logic [REG_ADDR_W-1:0] wb_rd;

    logic                  ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic                  haz_a, haz_b, issue;
    logic [1:0]            next_a, next_b;

    // Register 0 is hard-wired to zero, so it never produces a dependency.
    function automatic logic tag_match(input logic                  v,
                                       input logic                  rw,
                                       input logic [REG_ADDR_W-1:0] rd,
                                       input logic [REG_ADDR_W-1:0] src);
        return v & rw & (rd != '0) & (rd == src);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign ex_hit_a  = id_use_rs & tag_match(ex_v,  ex_rw,  ex_rd,  id_rs);
    assign ex_hit_b  = id_use_rt & tag_match(ex_v,  ex_rw,  ex_rd,  id_rt);
    assign mem_hit_a = id_use_rs & tag_match(mem_v, mem_rw, mem_rd, id_rs);
    assign mem_hit_b = id_use_rt & tag_match(mem_v, mem_rw, mem_rd, id_rt);

`ifdef FWD_HAZARD_FWD_EN
    // Only a load in EX cannot be forwarded in time; everything else is
    // covered by the muxes. EX wins over MEM because it holds the newer value.
    assign haz_a  = id_valid & ex_mr & ex_hit_a;
    assign haz_b  = id_valid & ex_mr & ex_hit_b;
    assign next_a = ex_hit_a ? 2'b10 : (mem_hit_a ? 2'b01 : 2'b00);
    assign next_b = ex_hit_b ? 2'b10 : (mem_hit_b ? 2'b01 : 2'b00);

    // WB producers are covered by the write-first register file.
    logic unused_tags;
    assign unused_tags = ^{wb_v, wb_rw, wb_rd};
`else
    // Without forwarding any producer still in EX or MEM must drain to WB.
    assign haz_a  = id_valid & (ex_hit_a | mem_hit_a);
    assign haz_b  = id_valid & (ex_hit_b | mem_hit_b);
    assign next_a = 2'b00;
    assign next_b = 2'b00;

    logic unused_tags;
    assign unused_tags = ^{wb_v, wb_rw, wb_rd, ex_mr};
`endif

    assign stall = (haz_a | haz_b) & ~flush_id;
    assign issue = id_valid & ~flush_id & ~stall;

    // ID -> EX boundary: tag pipeline, select registers and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v        <= 1'b0;
            ex_rw       <= 1'b0;
            ex_mr       <= 1'b0;
            ex_rd       <= '0;
            mem_v       <= 1'b0;
            mem_rw      <= 1'b0;
            mem_rd      <= '0;
            wb_v        <= 1'b0;
            wb_rw       <= 1'b0;
            wb_rd       <= '0;
            fwd_a_sel   <= 2'b00;
            fwd_b_sel   <= 2'b00;
            stall_count <= '0;
        end else if (!hold) begin
            wb_v        <= mem_v;
            wb_rw       <= mem_rw;
            wb_rd       <= mem_rd;
            mem_v       <= ex_v;
            mem_rw      <= ex_rw;
            mem_rd      <= ex_rd;
            // A bubble is marked by ex_v=0; the other tag fields are don't-care.
            ex_v        <= issue;
            ex_rw       <= id_regwrite;
            ex_mr       <= id_memread;
            ex_rd       <= id_rd;
            fwd_a_sel   <= issue ? next_a : 2'b00;
            fwd_b_sel   <= issue ? next_b : 2'b00;
            if (stall) begin
                stall_count <= sat_inc(stall_count);
            end
        end
    end

endmodule
